// File: rtl/decoder_scan_sequencer.sv
// Round-robin select/enable driver for a 2-to-4 line decoder, with lane mask and optional blanking gap.
// Optional feature: define SCAN_HOLD_EN to add a 'hold' input that freezes the dwell/blank counters.
module decoder_scan_sequencer #(
  parameter int DIV_W        = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic [3:0]       mask,
`ifdef SCAN_HOLD_EN
  input  logic             hold,
`endif
  output logic [1:0]       sel,
  output logic             en,
  output logic             wrap,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

  localparam logic [3:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? 4'(BLANK_CYCLES - 1) : 4'd0;

  state_t           state;
  logic [DIV_W-1:0] dwell_cnt;
  logic [3:0]       blank_cnt;
  logic [1:0]       nxt;
  logic             frozen;

`ifdef SCAN_HOLD_EN
  assign frozen = hold;
`else
  assign frozen = 1'b0;
`endif

  // Lowest set bit of the mask; caller guarantees mask != 0.
  function automatic logic [1:0] lowest_lane(input logic [3:0] m);
    logic [1:0] low;
    low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) low = 2'(i);
    end
    return low;
  endfunction

  // Next set bit after cur, circular; smallest offset wins, cur itself if it is the only one.
  function automatic logic [1:0] next_lane(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = cur;
    for (int i = 3; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (m[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign nxt = next_lane(sel, mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 2'd0;
      en        <= 1'b0;
      wrap      <= 1'b0;
      busy      <= 1'b0;
      dwell_cnt <= '0;
      blank_cnt <= 4'd0;
    end else begin
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (run && (mask != 4'd0)) begin
            state     <= ACTIVE;
            sel       <= lowest_lane(mask);
            dwell_cnt <= div;
            en        <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!frozen) begin
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end else if (!run || (mask == 4'd0)) begin
              state <= IDLE;
              en    <= 1'b0;
              busy  <= 1'b0;
            end else begin
              sel  <= nxt;
              wrap <= (nxt <= sel);
              if (BLANK_CYCLES > 0) begin
                state     <= BLANK;
                en        <= 1'b0;
                blank_cnt <= BLANK_LOAD;
              end else begin
                dwell_cnt <= div;
              end
            end
          end
        end
        BLANK: begin
          // sel already points at the new lane; the mask is deliberately not rechecked here.
          if (!frozen) begin
            if (blank_cnt != 4'd0) begin
              blank_cnt <= blank_cnt - 1'b1;
            end else if (run) begin
              state     <= ACTIVE;
              dwell_cnt <= div;
              en        <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          en    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer: scan patterns, masks, stop behaviour, async reset, optional hold.
module tb_decoder_scan_sequencer;

  localparam int DIV_W = 16;
  localparam int BLANK = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [3:0]       mask = 4'd0;
`ifdef SCAN_HOLD_EN
  logic             hold = 1'b0;
`endif
  logic [1:0]       sel;
  logic             en;
  logic             wrap;
  logic             busy;

  int tests = 0;
  int fails = 0;

  decoder_scan_sequencer #(.DIV_W(DIV_W), .BLANK_CYCLES(BLANK)) dut (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .div  (div),
    .mask (mask),
`ifdef SCAN_HOLD_EN
    .hold (hold),
`endif
    .sel  (sel),
    .en   (en),
    .wrap (wrap),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Expected {sel,en,wrap} at observation s (s=1 is the first cycle after run is sampled).
  // lanes holds the visit order, 2 bits per entry; dw is the dwell length (div+1).
  function automatic logic [3:0] scan_model(input int s, input int dw, input int n, input logic [7:0] lanes);
    int t, k, r;
    logic [1:0] cur, nx;
    t   = s - 1;
    k   = t / (dw + BLANK);
    r   = t % (dw + BLANK);
    cur = lanes[2*(k % n) +: 2];
    nx  = lanes[2*((k + 1) % n) +: 2];
    if (r < dw) return {cur, 1'b1, 1'b0};
    return {nx, 1'b0, (r == dw) && (nx <= cur)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++;
    if ({sel, en, wrap, busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_state: got sel=%0d en=%b wrap=%b busy=%b, want all 0", sel, en, wrap, busy);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_full_scan();
    logic [3:0] exp;
    do_reset();
    mask = 4'b1111; div = 16'd2; run = 1'b1;
    for (int s = 1; s <= 22; s++) begin
      step();
      exp = scan_model(s, 3, 4, 8'b11_10_01_00);
      tests++;
      if ({sel, en, wrap} !== exp || busy !== 1'b1) begin
        fails++;
        $display("FAIL full_scan[%0d]: got sel=%0d en=%b wrap=%b busy=%b, want sel=%0d en=%b wrap=%b busy=1",
                 s, sel, en, wrap, busy, exp[3:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_sparse_mask();
    logic [3:0] exp;
    do_reset();
    mask = 4'b1010; div = 16'd0; run = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      step();
      exp = scan_model(s, 1, 2, 8'b00_00_11_01);
      tests++;
      if ({sel, en, wrap} !== exp) begin
        fails++;
        $display("FAIL sparse_mask[%0d]: got sel=%0d en=%b wrap=%b, want sel=%0d en=%b wrap=%b",
                 s, sel, en, wrap, exp[3:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_single_lane();
    logic [3:0] exp;
    do_reset();
    mask = 4'b0100; div = 16'd1; run = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      step();
      exp = scan_model(s, 2, 1, 8'b00_00_00_10);
      tests++;
      if ({sel, en, wrap} !== exp) begin
        fails++;
        $display("FAIL single_lane[%0d]: got sel=%0d en=%b wrap=%b, want sel=%0d en=%b wrap=%b",
                 s, sel, en, wrap, exp[3:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_stop();
    // run high with an empty mask never leaves IDLE
    do_reset();
    mask = 4'b0000; div = 16'd3; run = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      step();
      tests++;
      if (busy !== 1'b0 || en !== 1'b0) begin
        fails++;
        $display("FAIL empty_mask[%0d]: got busy=%b en=%b, want 0 0", s, busy, en);
      end
    end
    // mask cleared mid-dwell: dwell of 4 completes, then IDLE
    do_reset();
    mask = 4'b1111; div = 16'd3; run = 1'b1;
    step();
    mask = 4'b0000;
    for (int s = 2; s <= 6; s++) begin
      step();
      tests++;
      if (s <= 4 && (en !== 1'b1 || busy !== 1'b1 || sel !== 2'd0)) begin
        fails++;
        $display("FAIL mask_drop_dwell[%0d]: got en=%b busy=%b sel=%0d, want 1 1 0", s, en, busy, sel);
      end else if (s > 4 && (en !== 1'b0 || busy !== 1'b0 || sel !== 2'd0)) begin
        fails++;
        $display("FAIL mask_drop_idle[%0d]: got en=%b busy=%b sel=%0d, want 0 0 0", s, en, busy, sel);
      end
    end
    // run dropped mid-dwell: dwell completes on lane 1, sel holds in IDLE
    do_reset();
    mask = 4'b0110; div = 16'd3; run = 1'b1;
    step();
    run = 1'b0;
    for (int s = 2; s <= 6; s++) begin
      step();
      tests++;
      if (s <= 4 && (en !== 1'b1 || sel !== 2'd1)) begin
        fails++;
        $display("FAIL run_drop_dwell[%0d]: got en=%b sel=%0d, want 1 1", s, en, sel);
      end else if (s > 4 && (en !== 1'b0 || busy !== 1'b0 || sel !== 2'd1)) begin
        fails++;
        $display("FAIL run_drop_idle[%0d]: got en=%b busy=%b sel=%0d, want 0 0 1", s, en, busy, sel);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mask = 4'b1100; div = 16'd5; run = 1'b1;
    step();
    step();
    tests++;
    if (sel !== 2'd2 || en !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: got sel=%0d en=%b, want 2 1", sel, en);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (sel !== 2'd0 || en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got sel=%0d en=%b busy=%b, want 0 0 0", sel, en, busy);
    end
    mask = 4'b0110;
    rst = 1'b0;
    step();
    tests++;
    if (sel !== 2'd1 || en !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart: got sel=%0d en=%b busy=%b, want 1 1 1", sel, en, busy);
    end
  endtask

`ifdef SCAN_HOLD_EN
  task automatic test_hold();
    int high;
    do_reset();
    mask = 4'b1111; div = 16'd3; run = 1'b1;
    step();
    step();
    hold = 1'b1;
    for (int s = 0; s < 5; s++) step();
    hold = 1'b0;
    high = 7;
    for (int s = 0; s < 20 && en === 1'b1; s++) begin
      step();
      if (en === 1'b1) high++;
    end
    tests++;
    if (high !== 9 || sel !== 2'd1) begin
      fails++;
      $display("FAIL hold_dwell: got en-high=%0d next sel=%0d, want 9 1", high, sel);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_scan();
    test_sparse_mask();
    test_single_lane();
    test_stop();
    test_async_reset();
`ifdef SCAN_HOLD_EN
    test_hold();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
